// File: rtl/cpu_mem_pkg.sv
// Shared memory types and address-field constants for the CPU datapath RAMs.
package cpu_mem_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned DEPTH       = 512;
  localparam int unsigned N_BANKS     = 8;
  localparam int unsigned BANK_DEPTH  = 64;
  localparam int unsigned BANK_ADDR_W = 6;

  localparam int unsigned BANK_MSB = 8;
  localparam int unsigned BANK_LSB = 6;
  localparam int unsigned WORD_MSB = 5;

  typedef logic [WORD_W-1:0] word_t;

  // Even parity over a data word, as stored alongside the word when parity is built in.
  function automatic logic even_par(input word_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_64.sv
// 64-word bank: synchronous write/reset, asynchronous read.
// Optional per-word parity storage and check under RAM512_PARITY_EN.
module ram_64
  import cpu_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  word_t                  in,
  input  logic [BANK_ADDR_W-1:0] sel,
  input  logic                   load,
`ifdef RAM512_PARITY_EN
  output logic                   perr,
`endif
  output word_t                  out
);

  word_t r_mem [BANK_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BANK_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (load) begin
      r_mem[sel] <= in;
    end
  end

  assign out = r_mem[sel];

`ifdef RAM512_PARITY_EN
  logic r_par [BANK_DEPTH];

  // Parity captured from the write data so a later corruption of r_mem is detectable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BANK_DEPTH); i++) begin
        r_par[i] <= 1'b0;
      end
    end else if (load) begin
      r_par[sel] <= even_par(in);
    end
  end

  assign perr = (even_par(r_mem[sel]) != r_par[sel]);
`endif

endmodule

// File: rtl/ram_512.sv
// 512 x 16 RAM built from eight 64-word banks; sel[8:6] picks the bank, sel[5:0] the word.
// Optional parity check output perr when RAM512_PARITY_EN is defined.
module ram_512
  import cpu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  word_t             in,
  input  logic [ADDR_W-1:0] sel,
  input  logic              load,
`ifdef RAM512_PARITY_EN
  output logic              perr,
`endif
  output word_t             out
);

  logic [BANK_LSB-1:0]             w_word;
  logic [BANK_MSB-BANK_LSB:0]      w_bank;
  logic [N_BANKS-1:0]              w_load;
  word_t                           w_bank_out [N_BANKS];
`ifdef RAM512_PARITY_EN
  logic [N_BANKS-1:0]              w_bank_perr;
`endif

  assign w_bank = sel[BANK_MSB:BANK_LSB];
  assign w_word = sel[WORD_MSB:0];

  // Load demux: only the addressed bank sees a write strobe.
  for (genvar b = 0; b < int'(N_BANKS); b++) begin : g_bank
    assign w_load[b] = load & (w_bank == 3'(b));

    ram_64 u_bank (
      .clk  (clk),
      .rst  (rst),
      .in   (in),
      .sel  (w_word),
      .load (w_load[b]),
`ifdef RAM512_PARITY_EN
      .perr (w_bank_perr[b]),
`endif
      .out  (w_bank_out[b])
    );
  end

  assign out = w_bank_out[w_bank];

`ifdef RAM512_PARITY_EN
  assign perr = w_bank_perr[w_bank];
`endif

endmodule

// File: tb/tb_ram_512.sv
// Directed bench for ram_512 with an array reference model checked every cycle.
module tb_ram_512;
  import cpu_mem_pkg::*;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       load = 1'b0;
  word_t      d_in = '0;
  logic [8:0] sel  = '0;
  word_t      q;
`ifdef RAM512_PARITY_EN
  logic       perr;
`endif

  int    n_chk  = 0;
  int    n_fail = 0;
  word_t model [512];
  bit    model_ok = 1'b0;

  always #5 clk = ~clk;

  ram_512 dut (
    .clk  (clk),
    .rst  (rst),
    .in   (d_in),
    .sel  (sel),
    .load (load),
`ifdef RAM512_PARITY_EN
    .perr (perr),
`endif
    .out  (q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a plain array updated by the write rules at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) model[i] = '0;
      model_ok = 1'b1;
    end else if (load) begin
      model[sel] = d_in;
    end
  end

  // Per-cycle compare, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check($sformatf("cycle_out@%0d", sel), 32'(q), 32'(model[sel]));
`ifdef RAM512_PARITY_EN
      check($sformatf("cycle_perr@%0d", sel), 32'(perr), 32'd0);
`endif
    end
  end

  task automatic edge_(input logic r, input logic l, input word_t d, input logic [8:0] s);
    rst = r; load = l; d_in = d; sel = s;
    @(posedge clk);
    #2;
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic rd(input logic [8:0] s, input word_t exp, input string nm);
    @(negedge clk);
    #1;
    sel = s;
    #1;
    check(nm, 32'(q), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #2;

    // Reset and sweep
    edge_(1'b1, 1'b0, '0, 9'd0);
    rd(9'd0,   16'h0000, "reset_0");
    rd(9'd128, 16'h0000, "reset_128");
    rd(9'd511, 16'h0000, "reset_511");

    // Basic writes
    edge_(1'b0, 1'b1, 16'hC0DE, 9'd0);
    edge_(1'b0, 1'b1, 16'hDEAF, 9'd128);
    edge_(1'b0, 1'b1, 16'hF00D, 9'd511);
    rd(9'd0,   16'hC0DE, "wr_0");
    rd(9'd128, 16'hDEAF, "wr_128");
    rd(9'd511, 16'hF00D, "wr_511");

    // Write inhibit
    edge_(1'b0, 1'b0, 16'h1234, 9'd128);
    rd(9'd128, 16'hDEAF, "inhibit_128");
    rd(9'd127, 16'h0000, "inhibit_127");
    rd(9'd129, 16'h0000, "inhibit_129");

    // Overwrite across a bank boundary
    edge_(1'b0, 1'b1, 16'hABCD, 9'd63);
    edge_(1'b0, 1'b1, 16'h5555, 9'd64);
    edge_(1'b0, 1'b1, 16'h9999, 9'd63);
    rd(9'd63, 16'h9999, "overwrite_63");
    rd(9'd64, 16'h5555, "bank_edge_64");

    // Read during write: old word before the edge, new word after
    @(negedge clk); #1;
    sel = 9'd200; d_in = 16'h7777; load = 1'b1;
    #1;
    check("rdw_old", 32'(q), 32'h0000);
    @(posedge clk); #1;
    check("rdw_new", 32'(q), 32'h7777);
    load = 1'b0;

    // Writes into every bank at first, middle and last word
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 3; k++) begin
        int a;
        a = b * 64 + ((k == 0) ? 0 : (k == 1) ? 31 : 63);
        edge_(1'b0, 1'b1, 16'(a * 97 + 16'h0101), 9'(a));
      end
    end
    rd(9'd191, 16'h4960, "bank2_last");
    rd(9'd448, 16'(448 * 97 + 257), "bank7_first");
    rd(9'd200, 16'h7777, "rdw_kept");

    // Full address sweep with load=0 and junk data; per-cycle compare covers every word
    for (int i = 0; i < 512; i++) begin
      edge_(1'b0, 1'b0, 16'hFFFF, 9'(i));
    end

`ifdef RAM512_PARITY_EN
    // Corrupt one stored bit behind the parity and expect perr at that address only
    @(negedge clk); #1;
    sel = 9'd64;
    #1;
    check("perr_clean", 32'(perr), 32'd0);
    dut.g_bank[1].u_bank.r_mem[0][3] = ~dut.g_bank[1].u_bank.r_mem[0][3];
    #1;
    check("perr_flip", 32'(perr), 32'd1);
    sel = 9'd65;
    #1;
    check("perr_other", 32'(perr), 32'd0);
    sel = 9'd64;
    dut.g_bank[1].u_bank.r_mem[0][3] = ~dut.g_bank[1].u_bank.r_mem[0][3];
    #1;
    check("perr_restored", 32'(perr), 32'd0);
`endif

    // Reset dominates load
    edge_(1'b1, 1'b1, 16'hFFFF, 9'd0);
    rd(9'd0,   16'h0000, "rstdom_0");
    rd(9'd63,  16'h0000, "rstdom_63");
    rd(9'd64,  16'h0000, "rstdom_64");
    rd(9'd128, 16'h0000, "rstdom_128");
    rd(9'd200, 16'h0000, "rstdom_200");
    rd(9'd511, 16'h0000, "rstdom_511");

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
